// File: rtl/regfile_scan_reader.sv
// regfile_scan_reader
//
// Sequential read-out engine for the CPU register file. A start pulse walks
// register indices 0..REG_FILE_SIZE-1 through the register file read port,
// snapshots each word and emits the words in order on a valid/ready stream.
// Used for debug dumps and context save. Only the read side of the register
// file is touched: the read index goes out, the combinational data comes back.
//
// Optional feature macro: REGFILE_SCAN_CHECKSUM_EN
//   When defined, a 32-bit XOR of every captured word is appended to the
//   stream as an extra word with out_idx_o = REG_FILE_SIZE. That checksum
//   word is the one that carries out_last_o.
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset
//   start_i        begin a scan (sampled only while idle)
//   busy_o         scan in progress (READ/HOLD/CSUM/DONE)
//   done_o         one-cycle pulse the cycle after the final word is accepted
//   rd_reg_num_o   read index to the register file (internal index counter)
//   read_data_i    combinational read data from the register file
//   out_valid_o    stream word available
//   out_ready_i    consumer accepts when out_valid_o && out_ready_i
//   out_data_o     captured register word (or checksum)
//   out_idx_o      index of the word in out_data_o
//   out_last_o     marks the final word of the scan

module regfile_scan_reader #(
    parameter int REG_FILE_SIZE = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [5:0]  rd_reg_num_o,
    input  logic [31:0] read_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic [5:0]  out_idx_o,
    output logic        out_last_o
);

    localparam logic [5:0] LAST_IDX = 6'(REG_FILE_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        HOLD,
`ifdef REGFILE_SCAN_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic        busy_q, busy_d;
    logic [31:0] out_data_q, out_data_d;
    logic [5:0]  out_idx_q, out_idx_d;
    logic        handshake;

`ifdef REGFILE_SCAN_CHECKSUM_EN
    localparam logic [5:0] CSUM_IDX = 6'(REG_FILE_SIZE);
    logic [31:0] acc_q, acc_d;
`endif

    assign handshake = (state_q == HOLD) && out_ready_i;

    // Next-state and datapath update. Every register holds by default; the
    // READ cycle is the only place a register-file word is sampled, which
    // gives snapshot semantics: a write landing on that same edge is not seen.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
`ifdef REGFILE_SCAN_CHECKSUM_EN
        acc_d      = acc_q;
`endif

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = READ;
                    idx_d   = 6'd0;
                    busy_d  = 1'b1;
`ifdef REGFILE_SCAN_CHECKSUM_EN
                    acc_d   = 32'd0;
`endif
                end
            end

            READ: begin
                out_data_d = read_data_i;
                out_idx_d  = idx_q;
`ifdef REGFILE_SCAN_CHECKSUM_EN
                acc_d      = acc_q ^ read_data_i;
`endif
                state_d    = HOLD;
            end

            HOLD: begin
                if (handshake) begin
`ifdef REGFILE_SCAN_CHECKSUM_EN
                    // The checksum word reuses HOLD; idx_q still sits on the
                    // last register, so test for the checksum word first.
                    if (out_idx_q == CSUM_IDX) begin
                        state_d = DONE;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = CSUM;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = READ;
                    end
`else
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = READ;
                    end
`endif
                end
            end

`ifdef REGFILE_SCAN_CHECKSUM_EN
            CSUM: begin
                out_data_d = acc_q;
                out_idx_d  = CSUM_IDX;
                state_d    = HOLD;
            end
`endif

            DONE: begin
                // Return the read index to 0 so it reads 0 throughout IDLE.
                busy_d  = 1'b0;
                idx_d   = 6'd0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset abandons any scan in
    // flight without a done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            idx_q      <= 6'd0;
            busy_q     <= 1'b0;
            out_data_q <= 32'd0;
            out_idx_q  <= 6'd0;
`ifdef REGFILE_SCAN_CHECKSUM_EN
            acc_q      <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
`ifdef REGFILE_SCAN_CHECKSUM_EN
            acc_q      <= acc_d;
`endif
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = (state_q == DONE);
    assign rd_reg_num_o = idx_q;
    assign out_valid_o  = (state_q == HOLD);
    assign out_data_o   = out_data_q;
    assign out_idx_o    = out_idx_q;

    // With the checksum enabled only the checksum word is marked last.
`ifdef REGFILE_SCAN_CHECKSUM_EN
    assign out_last_o = (out_idx_q == CSUM_IDX);
`else
    assign out_last_o = (out_idx_q == LAST_IDX);
`endif

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Testbench for regfile_scan_reader: a 32-entry instance and a 2-entry
// instance, each with a register-file model and a scoreboard queue that a
// negedge monitor drains on every stream handshake.

module tb_regfile_scan_reader;

    localparam int N = 32;
    localparam int N2 = 2;
`ifdef REGFILE_SCAN_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  idx;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, busy, done, outValid, outReady, outLast;
    logic [5:0]  rdRegNum, outIdx;
    logic [31:0] readData, outData;
    logic        start2, busy2, done2, outValid2, outReady2, outLast2;
    logic [5:0]  rdRegNum2, outIdx2;
    logic [31:0] readData2, outData2;

    logic [31:0] regs  [64];
    logic [31:0] regs2 [64];
    logic        preload, wrEn;
    logic [5:0]  wrAddr;
    logic [31:0] wrData;

    word_t expQ[$];
    word_t expQ2[$];
    int compared = 0;
    int mismatched = 0;
    int doneCount = 0;

    always #5 clk = ~clk;

    regfile_scan_reader #(.REG_FILE_SIZE(N)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
        .rd_reg_num_o(rdRegNum), .read_data_i(readData), .out_valid_o(outValid),
        .out_ready_i(outReady), .out_data_o(outData), .out_idx_o(outIdx),
        .out_last_o(outLast)
    );

    regfile_scan_reader #(.REG_FILE_SIZE(N2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .busy_o(busy2), .done_o(done2),
        .rd_reg_num_o(rdRegNum2), .read_data_i(readData2), .out_valid_o(outValid2),
        .out_ready_i(outReady2), .out_data_o(outData2), .out_idx_o(outIdx2),
        .out_last_o(outLast2)
    );

    assign readData  = regs[rdRegNum];
    assign readData2 = regs2[rdRegNum2];

    // Register-file model: writes land on the clock edge, like the real file.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) begin
                regs[i]  <= 32'(32'h100 + i);
                regs2[i] <= 32'd0;
            end
            regs2[0] <= 32'hA5A5A5A5;
            regs2[1] <= 32'h0F0F0F0F;
        end else if (wrEn) begin
            regs[wrAddr] <= wrData;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
        end
    endtask

    // Monitor for the 32-entry instance: pops on handshake, checks the held
    // word against the queue head while stalled.
    always @(negedge clk) begin
        word_t e;
        if (!rst) begin
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_word: actual idx %0d data %h, required none",
                             outIdx, outData);
                end else begin
                    e = expQ.pop_front();
                    checkOutput($sformatf("word_data@%0d", e.idx), outData, e.data);
                    checkOutput($sformatf("word_idx@%0d", e.idx), 32'(outIdx), 32'(e.idx));
                    checkOutput($sformatf("word_last@%0d", e.idx), 32'(outLast), 32'(e.last));
                end
            end else if (outValid && expQ.size() > 0) begin
                checkOutput("stall_data", outData, expQ[0].data);
                checkOutput("stall_idx", 32'(outIdx), 32'(expQ[0].idx));
            end
            if (done) doneCount++;
        end
    end

    // Monitor for the 2-entry instance.
    always @(negedge clk) begin
        word_t e;
        if (!rst && outValid2 && outReady2) begin
            if (expQ2.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_word2: actual idx %0d data %h, required none",
                         outIdx2, outData2);
            end else begin
                e = expQ2.pop_front();
                checkOutput($sformatf("small_data@%0d", e.idx), outData2, e.data);
                checkOutput($sformatf("small_idx@%0d", e.idx), 32'(outIdx2), 32'(e.idx));
                checkOutput($sformatf("small_last@%0d", e.idx), 32'(outLast2), 32'(e.last));
            end
        end
    end

    // One full scan of the 32-entry instance. Optional backpressure (5 stall
    // cycles per word), a stray start at a given index, and a register-file
    // write during the READ cycle of a given index.
    task automatic applyStimulus(input bit stall, input int midStartIdx, input int writeIdx);
        int lat;
        int expLat;
        int doneBefore;
        int holdCnt;
        bit midIssued;
        logic [31:0] acc;
        word_t w;
        acc = 32'd0;
        for (int i = 0; i < N; i++) begin
            w.data = regs[i];
            w.idx  = 6'(i);
            w.last = !CSUM_EN && (i == N - 1);
            expQ.push_back(w);
            acc ^= regs[i];
        end
        if (CSUM_EN) begin
            w.data = acc;
            w.idx  = 6'(N);
            w.last = 1'b1;
            expQ.push_back(w);
        end
        expLat = 2 * N + 1 + (CSUM_EN ? 2 : 0) + (stall ? 5 * (N + (CSUM_EN ? 1 : 0)) : 0);
        doneBefore = doneCount;
        outReady = !stall;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        holdCnt = 0;
        midIssued = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        checkOutput("valid_in_read", 32'(outValid), 32'd0);
        while (!done && lat < 2000) begin
            if (lat == 2) checkOutput("valid_two_after_start", 32'(outValid), 32'd1);
            start = 1'b0;
            wrEn = 1'b0;
            if (stall) begin
                if (outValid) begin
                    if (holdCnt < 5) begin
                        outReady = 1'b0;
                        holdCnt++;
                    end else begin
                        outReady = 1'b1;
                        holdCnt = 0;
                    end
                end else begin
                    outReady = 1'b0;
                end
            end
            if (midStartIdx >= 0 && !midIssued && outValid && rdRegNum == 6'(midStartIdx)) begin
                start = 1'b1;
                midIssued = 1'b1;
            end
            if (writeIdx >= 0 && busy && !outValid && rdRegNum == 6'(writeIdx)) begin
                wrEn = 1'b1;
                wrAddr = 6'(writeIdx);
                wrData = 32'hDEADBEEF;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        wrEn = 1'b0;
        checkOutput("done_seen", 32'(done), 32'd1);
        checkOutput("done_latency", 32'(lat), 32'(expLat));
        @(posedge clk); #1;
        checkOutput("busy_after_done", 32'(busy), 32'd0);
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("rd_idx_idle", 32'(rdRegNum), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("done_pulses", 32'(doneCount - doneBefore), 32'd1);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        outReady = 1'b1;
    endtask

    // Reset while holding the word at idx 7, then confirm everything is idle.
    task automatic resetMidScan();
        int lat;
        int doneBefore;
        word_t w;
        for (int i = 0; i < N; i++) begin
            w.data = regs[i];
            w.idx  = 6'(i);
            w.last = !CSUM_EN && (i == N - 1);
            expQ.push_back(w);
        end
        doneBefore = doneCount;
        outReady = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!(outValid && rdRegNum == 6'd7) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("reached_idx7", 32'(rdRegNum), 32'd7);
        outReady = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        expQ.delete();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(outValid), 32'd0);
        checkOutput("rst_rd_idx", 32'(rdRegNum), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_out_idx", 32'(outIdx), 32'd0);
        outReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_no_done", 32'(doneCount - doneBefore), 32'd0);
        checkOutput("rst_stays_idle", 32'(busy), 32'd0);
    endtask

    // Two-entry scan with hand-computed words and checksum.
    task automatic scanSmall();
        int lat;
        word_t w;
        w.data = 32'hA5A5A5A5; w.idx = 6'd0; w.last = 1'b0;
        expQ2.push_back(w);
        w.data = 32'h0F0F0F0F; w.idx = 6'd1; w.last = !CSUM_EN;
        expQ2.push_back(w);
        if (CSUM_EN) begin
            w.data = 32'hAAAAAAAA; w.idx = 6'd2; w.last = 1'b1;
            expQ2.push_back(w);
        end
        outReady2 = 1'b1;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        lat = 1;
        while (!done2 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("small_done_seen", 32'(done2), 32'd1);
        checkOutput("small_done_latency", 32'(lat), CSUM_EN ? 32'd7 : 32'd5);
        @(posedge clk); #1;
        checkOutput("small_busy_after", 32'(busy2), 32'd0);
        checkOutput("small_queue_drained", 32'(expQ2.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        outReady = 1'b0;
        outReady2 = 1'b0;
        preload = 1'b1;
        wrEn = 1'b0;
        wrAddr = 6'd0;
        wrData = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        rst = 1'b0;

        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_valid", 32'(outValid), 32'd0);
        checkOutput("reset_data", outData, 32'd0);
        checkOutput("reset_idx", 32'(outIdx), 32'd0);
        checkOutput("reset_last", 32'(outLast), 32'd0);
        checkOutput("reset_rd_idx", 32'(rdRegNum), 32'd0);
        checkOutput("reset_busy_small", 32'(busy2), 32'd0);

        $display("[TB] full scan, no backpressure");
        applyStimulus(1'b0, -1, -1);
        $display("[TB] full scan, 5-cycle stall per word");
        applyStimulus(1'b1, -1, -1);
        $display("[TB] write to reg 5 during its READ cycle");
        applyStimulus(1'b0, -1, 5);
        checkOutput("reg5_written", regs[5], 32'hDEADBEEF);
        $display("[TB] rescan after write");
        applyStimulus(1'b0, -1, -1);
        $display("[TB] stray start at idx 10");
        applyStimulus(1'b0, 10, -1);
        $display("[TB] reset mid-scan");
        resetMidScan();
        applyStimulus(1'b0, -1, -1);
        $display("[TB] two-entry instance");
        scanSmall();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
